dff_pipe: RTL and testbench
===========================

# dff_pipe

Parametrised register pipeline: the next generation of the plain `Dff` register. It adds configurable depth, per-stage valid tracking, a global advance enable (stall), a synchronous flush and a synchronous reset to a programmable value. It sits anywhere a fixed-latency, stallable delay line is needed, for example when retiming datapaths or balancing latency between parallel paths.

## Interface
- `WIDTH`, 8: data width in bits; must be ≥ 1.
- `DEPTH`, 2: number of register stages, which is also the latency; must be ≥ 1.
- `RESET_VALUE`, `'0`: value loaded into every data stage on reset (`WIDTH` bits).

Ports (name, direction, width, meaning):
- `clk` — input — 1 — single clock; everything is rising-edge.
- `rst` — input — 1 — synchronous, active-high reset.
- `en` — input — 1 — advance; when high, all stages shift by one.
- `flush` — input — 1 — synchronous clear of all valid bits.
- `in` — input — `WIDTH` — data into stage 0.
- `in_valid` — input — 1 — qualifies `in`.
- `out` — output — `WIDTH` — data of stage `DEPTH-1`.
- `out_valid` — output — 1 — valid bit of stage `DEPTH-1`.
- `occupancy` — output — `$clog2(DEPTH+1)` — number of valid stages. Present only with `DFF_PIPE_OCCUPANCY_EN`.

## Operation
- Each stage `i` holds `data[i]` and `valid[i]`. Stage 0 is fed by `in` / `in_valid`. Stage `i` is fed by stage `i-1`.
- Priority is `rst` > `flush` > `en` > hold.
- **Reset** (`rst`=1 at an edge):
  - `data[*]` ← `RESET_VALUE`; `valid[*]` ← 0; `occupancy` ← 0.
  - Reset in the middle of a transfer discards all in-flight entries.
- **Flush** (`flush`=1, `rst`=0):
  - `valid[*]` ← 0; `occupancy` ← 0.
  - `data[*]` holds its value.
  - `in` / `in_valid` presented in the same cycle are dropped, even if `en`=1.
- **Advance** (`en`=1, no rst/flush):
  - `data[0]` ← `in`; `valid[0]` ← `in_valid`.
  - `data[i]` ← `data[i-1]` and `valid[i]` ← `valid[i-1]`.
  - Stage `DEPTH-1`'s old content is retired.
  - Data shifts even when `in_valid`=0, so a bubble carries whatever value is on `in`.
- **Hold** (`en`=0): all stage state is unchanged. `out` and `out_valid` are stable.
- `out` and `out_valid` are driven directly from stage `DEPTH-1` registers. There is no combinational path from any input to any output.
- With `DEPTH`=1 the block behaves as a single enabled Dff with a valid bit.

## Timing
- Latency: a word accepted at edge N appears on `out` after the edge at which the `DEPTH`-th advance (counting edge N as the first) occurs. With `en` held high, that is `DEPTH` cycles.
- Stalls add one cycle per `en`=0 cycle. Words are never lost or duplicated during a stall.
- Outputs after reset: `out` = `RESET_VALUE`, `out_valid` = 0, `occupancy` = 0, from the first edge with `rst`=1.
- Throughput: one word per cycle while `en`=1.
- A flush takes effect at the edge. From the next cycle `out_valid`=0, and the pipeline refills from `in` on later advances.

## Configuration
- `DFF_PIPE_OCCUPANCY_EN` defined:
  - Adds the `occupancy` port and its counter.
  - On advance: next count = count + `in_valid` − `valid[DEPTH-1]`. A simultaneous enter and retire leaves the count unchanged.
  - On hold: the count is unchanged.
  - The count never exceeds `DEPTH` and never underflows.
- Macro undefined: no `occupancy` port and no counter logic. All other behaviour is identical.

## Structure
- Package `dff_pkg`:
  - Function `occ_width(depth)` returning `$clog2(depth+1)`.
  - Localparam defaults: `DFF_DEFAULT_WIDTH` = 8, `DFF_DEFAULT_DEPTH` = 2.
- Sub-module `dff_stage`:
  - One register of `WIDTH` data bits plus 1 valid bit.
  - Ports: `clk`, `rst`, `en`, `clr`, `in`, `in_valid`, `out`, `out_valid`.
  - `dff_pipe` instantiates `DEPTH` of these in a generate loop and ties `clr` to `flush`.

## Test plan
- Reset check, `WIDTH`=2, `DEPTH`=3, `RESET_VALUE`=2'b10: assert `rst` for 2 cycles → `out`=2, `out_valid`=0, `occupancy`=0.
- Latency check, `en`=1 throughout: drive `in`=1 with `in_valid`=1 for one cycle, then `in_valid`=0 → `out`=1 with `out_valid`=1 exactly 3 cycles later, for exactly one cycle.
- Stall: stream 1, 3, 2 back-to-back, then drop `en` for 2 cycles mid-stream → output order is 1, 3, 2, with 2 extra cycles of latency and no duplicates.
- Flush: with 3 valid entries and `occupancy`=3, assert `flush` with `en`=1 and `in_valid`=1 → next cycle `out_valid`=0, `occupancy`=0, and the input is dropped.
- Random traffic: 200 cycles of random `in` (0–3), `in_valid` and `en` against a queue scoreboard → every valid output matches in order. `occupancy` equals the scoreboard count and stays ≤ 3.
- `DEPTH`=1, built with and without `DFF_PIPE_OCCUPANCY_EN`: drive `in`=3 → `out`=3 one cycle later. The build without the macro has no `occupancy` port.

Source files
------------

// File: rtl/dff_pkg.sv
// Shared defaults, occupancy width helper and pipeline operation decode for dff_pipe.
package dff_pkg;

    localparam int unsigned DFF_DEFAULT_WIDTH = 8;
    localparam int unsigned DFF_DEFAULT_DEPTH = 2;

    typedef enum logic [1:0] {
        OP_HOLD    = 2'd0,
        OP_ADVANCE = 2'd1,
        OP_FLUSH   = 2'd2
    } pipe_op_e;

    function automatic int unsigned occ_width(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

    // Flush outranks advance; reset is handled directly in each register process.
    function automatic pipe_op_e pipe_op(input logic clr, input logic en);
        if (clr) begin
            return OP_FLUSH;
        end
        if (en) begin
            return OP_ADVANCE;
        end
        return OP_HOLD;
    endfunction

endpackage

// File: rtl/dff_stage.sv
// One pipeline stage: WIDTH data bits plus a valid bit, with enable, clear and
// synchronous reset to RESET_VALUE. Clear drops the valid bit but keeps the data.
module dff_stage
    import dff_pkg::*;
#(
    parameter int unsigned       WIDTH       = DFF_DEFAULT_WIDTH,
    parameter logic [WIDTH-1:0]  RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    input  logic [WIDTH-1:0] in,
    input  logic             in_valid,
    output logic [WIDTH-1:0] out,
    output logic             out_valid
);

    logic [WIDTH-1:0] data_q, data_d;
    logic             valid_q, valid_d;

    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        unique case (pipe_op(clr, en))
            OP_FLUSH: begin
                valid_d = 1'b0;
            end
            OP_ADVANCE: begin
                data_d  = in;
                valid_d = in_valid;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_q  <= RESET_VALUE;
            valid_q <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    assign out       = data_q;
    assign out_valid = valid_q;

endmodule

// File: rtl/dff_pipe.sv
// Stallable, flushable fixed-latency register pipeline of DEPTH dff_stage instances.
// Define DFF_PIPE_OCCUPANCY_EN to add the occupancy port and its counter.
module dff_pipe
    import dff_pkg::*;
#(
    parameter int unsigned       WIDTH       = DFF_DEFAULT_WIDTH,
    parameter int unsigned       DEPTH       = DFF_DEFAULT_DEPTH,
    parameter logic [WIDTH-1:0]  RESET_VALUE = '0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         en,
    input  logic                         flush,
    input  logic [WIDTH-1:0]             in,
    input  logic                         in_valid,
    output logic [WIDTH-1:0]             out,
    output logic                         out_valid
`ifdef DFF_PIPE_OCCUPANCY_EN
    ,
    output logic [occ_width(DEPTH)-1:0]  occupancy
`endif
);

    logic [WIDTH-1:0] feed_data  [DEPTH];
    logic             feed_valid [DEPTH];
    logic [WIDTH-1:0] stage_data [DEPTH];
    logic             stage_valid[DEPTH];

    for (genvar g = 0; g < DEPTH; g++) begin : g_stage
        if (g == 0) begin : g_head
            assign feed_data[g]  = in;
            assign feed_valid[g] = in_valid;
        end else begin : g_tail
            assign feed_data[g]  = stage_data[g-1];
            assign feed_valid[g] = stage_valid[g-1];
        end

        dff_stage #(
            .WIDTH       (WIDTH),
            .RESET_VALUE (RESET_VALUE)
        ) u_stage (
            .clk       (clk),
            .rst       (rst),
            .en        (en),
            .clr       (flush),
            .in        (feed_data[g]),
            .in_valid  (feed_valid[g]),
            .out       (stage_data[g]),
            .out_valid (stage_valid[g])
        );
    end

    assign out       = stage_data[DEPTH-1];
    assign out_valid = stage_valid[DEPTH-1];

`ifdef DFF_PIPE_OCCUPANCY_EN
    localparam int unsigned OCC_W = occ_width(DEPTH);

    logic [OCC_W-1:0] occ_q, occ_d;

    // Tracks enter minus retire on each advance; out_valid is the retiring stage's valid bit.
    always_comb begin
        occ_d = occ_q;
        unique case (pipe_op(flush, en))
            OP_FLUSH: begin
                occ_d = '0;
            end
            OP_ADVANCE: begin
                if (in_valid && !out_valid) begin
                    occ_d = occ_q + OCC_W'(1);
                end else if (!in_valid && out_valid) begin
                    occ_d = occ_q - OCC_W'(1);
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            occ_q <= '0;
        end else begin
            occ_q <= occ_d;
        end
    end

    assign occupancy = occ_q;

    a_occ_bound: assert property (@(posedge clk) disable iff (rst) occ_q <= OCC_W'(DEPTH));
`endif

endmodule

// File: tb/tb_dff_pipe.sv
// Self-checking bench for dff_pipe (WIDTH=2, DEPTH=3, RESET_VALUE=2) plus a DEPTH=1 instance.
// Occupancy checks are active when DFF_PIPE_OCCUPANCY_EN is defined.
module tb_dff_pipe;

    localparam int unsigned W  = 2;
    localparam int unsigned D  = 3;
    localparam logic [1:0]  RV = 2'b10;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, en, flush, in_valid, out_valid;
    logic [1:0] in_d, out_d;
    logic       d1_rst, d1_en, d1_iv, d1_ov;
    logic [1:0] d1_in, d1_out;
`ifdef DFF_PIPE_OCCUPANCY_EN
    logic [1:0] occ;
    logic       d1_occ;
`endif

    dff_pipe #(
        .WIDTH       (W),
        .DEPTH       (D),
        .RESET_VALUE (RV)
    ) u_dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .flush     (flush),
        .in        (in_d),
        .in_valid  (in_valid),
        .out       (out_d),
        .out_valid (out_valid)
`ifdef DFF_PIPE_OCCUPANCY_EN
        ,
        .occupancy (occ)
`endif
    );

    dff_pipe #(
        .WIDTH       (W),
        .DEPTH       (1),
        .RESET_VALUE (2'b00)
    ) u_d1 (
        .clk       (clk),
        .rst       (d1_rst),
        .en        (d1_en),
        .flush     (1'b0),
        .in        (d1_in),
        .in_valid  (d1_iv),
        .out       (d1_out),
        .out_valid (d1_ov)
`ifdef DFF_PIPE_OCCUPANCY_EN
        ,
        .occupancy (d1_occ)
`endif
    );

    int n_assert = 0;
    int n_fail   = 0;

    typedef struct {
        logic        en;
        logic        iv;
        logic [1:0]  din;
        logic        exp_ov;
        logic [1:0]  exp_out;
        int unsigned exp_occ;
    } vec_t;
    vec_t vecs[$];

    typedef struct {
        logic [1:0]  data;
        int unsigned age;
    } sb_t;
    sb_t sb[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic r, input logic f, input logic e, input logic v,
                         input logic [1:0] d);
        rst      = r;
        flush    = f;
        en       = e;
        in_valid = v;
        in_d     = d;
    endtask

    task automatic add_vec(input logic e, input logic v, input logic [1:0] d,
                           input logic ov, input logic [1:0] o, input int unsigned oc);
        vec_t x;
        x.en = e; x.iv = v; x.din = d; x.exp_ov = ov; x.exp_out = o; x.exp_occ = oc;
        vecs.push_back(x);
    endtask

    // Scoreboard entries carry the number of advances seen; at age D the word sits on out.
    task automatic model_edge(input logic f, input logic e, input logic v, input logic [1:0] d);
        sb_t entry;
        if (f) begin
            sb.delete();
        end else if (e) begin
            if (sb.size() > 0 && sb[0].age == D) begin
                void'(sb.pop_front());
            end
            for (int i = 0; i < sb.size(); i++) begin
                sb[i].age = sb[i].age + 1;
            end
            if (v) begin
                entry.data = d;
                entry.age  = 1;
                sb.push_back(entry);
            end
        end
    endtask

    initial begin
        logic        r_en, r_fl, r_iv, exp_ov;
        logic [1:0]  r_d;

        // Latency, then stream 1,3,2 with a 2-cycle stall, then hold with a valid output.
        add_vec(1, 1, 1, 0, 0, 1);
        add_vec(1, 0, 0, 0, 0, 1);
        add_vec(1, 0, 0, 1, 1, 1);
        add_vec(1, 0, 0, 0, 0, 0);
        add_vec(1, 0, 0, 0, 0, 0);
        add_vec(1, 1, 1, 0, 0, 1);
        add_vec(1, 1, 3, 0, 0, 2);
        add_vec(0, 1, 2, 0, 0, 2);
        add_vec(0, 1, 2, 0, 0, 2);
        add_vec(1, 1, 2, 1, 1, 3);
        add_vec(1, 0, 0, 1, 3, 2);
        add_vec(1, 0, 0, 1, 2, 1);
        add_vec(1, 0, 0, 0, 0, 0);
        add_vec(1, 1, 3, 0, 0, 1);
        add_vec(1, 0, 0, 0, 0, 1);
        add_vec(1, 0, 0, 1, 3, 1);
        add_vec(0, 1, 1, 1, 3, 1);
        add_vec(0, 1, 1, 1, 3, 1);
        add_vec(1, 0, 0, 0, 0, 0);

        drive(1, 0, 0, 0, 0);
        d1_rst = 1'b1; d1_en = 1'b0; d1_iv = 1'b0; d1_in = 2'd0;

        for (int c = 0; c < 2; c++) begin
            step();
            chk("reset_out", out_d, RV);
            chk("reset_out_valid", out_valid, 0);
`ifdef DFF_PIPE_OCCUPANCY_EN
            chk("reset_occ", occ, 0);
`endif
        end

        for (int i = 0; i < vecs.size(); i++) begin
            drive(0, 0, vecs[i].en, vecs[i].iv, vecs[i].din);
            step();
            chk($sformatf("vec%0d_out_valid", i), out_valid, vecs[i].exp_ov);
            if (vecs[i].exp_ov) begin
                chk($sformatf("vec%0d_out", i), out_d, vecs[i].exp_out);
            end
`ifdef DFF_PIPE_OCCUPANCY_EN
            chk($sformatf("vec%0d_occ", i), occ, vecs[i].exp_occ);
`endif
        end

        // Flush with three valid entries; the word presented alongside must be dropped.
        for (int k = 1; k <= 3; k++) begin
            drive(0, 0, 1, 1, 2'(k));
            step();
        end
        chk("preflush_out", out_d, 1);
        chk("preflush_out_valid", out_valid, 1);
`ifdef DFF_PIPE_OCCUPANCY_EN
        chk("preflush_occ", occ, 3);
`endif
        drive(0, 1, 1, 1, 0);
        step();
        chk("flush_out_valid", out_valid, 0);
        chk("flush_data_held", out_d, 1);
`ifdef DFF_PIPE_OCCUPANCY_EN
        chk("flush_occ", occ, 0);
`endif
        for (int k = 0; k < 3; k++) begin
            drive(0, 0, 1, 0, 0);
            step();
            chk($sformatf("postflush%0d_out_valid", k), out_valid, 0);
`ifdef DFF_PIPE_OCCUPANCY_EN
            chk($sformatf("postflush%0d_occ", k), occ, 0);
`endif
        end

        // Reset while words are in flight discards them.
        drive(0, 0, 1, 1, 3); step();
        drive(0, 0, 1, 1, 3); step();
        drive(1, 0, 1, 1, 1); step();
        chk("midrst_out", out_d, RV);
        chk("midrst_out_valid", out_valid, 0);
`ifdef DFF_PIPE_OCCUPANCY_EN
        chk("midrst_occ", occ, 0);
`endif
        for (int k = 0; k < 3; k++) begin
            drive(0, 0, 1, 0, 0);
            step();
            chk($sformatf("postrst%0d_out_valid", k), out_valid, 0);
        end

        // Random traffic against the scoreboard (pipeline is empty here).
        sb.delete();
        for (int c = 0; c < 200; c++) begin
            r_en = ($urandom_range(0, 3) != 0);
            r_fl = ($urandom_range(0, 31) == 0);
            r_iv = 1'($urandom_range(0, 1));
            r_d  = 2'($urandom_range(0, 3));
            drive(0, r_fl, r_en, r_iv, r_d);
            model_edge(r_fl, r_en, r_iv, r_d);
            step();
            exp_ov = (sb.size() > 0) && (sb[0].age == D);
            chk($sformatf("rnd%0d_out_valid", c), out_valid, exp_ov);
            if (exp_ov) begin
                chk($sformatf("rnd%0d_out", c), out_d, sb[0].data);
            end
`ifdef DFF_PIPE_OCCUPANCY_EN
            chk($sformatf("rnd%0d_occ", c), occ, sb.size());
            chk($sformatf("rnd%0d_occ_bound", c), occ <= 2'd3, 1);
`endif
        end

        // DEPTH=1 instance.
        drive(0, 0, 0, 0, 0);
        step();
        chk("d1_reset_out", d1_out, 0);
        chk("d1_reset_out_valid", d1_ov, 0);
        d1_rst = 1'b0; d1_en = 1'b1; d1_iv = 1'b1; d1_in = 2'd3;
        step();
        chk("d1_out", d1_out, 3);
        chk("d1_out_valid", d1_ov, 1);
`ifdef DFF_PIPE_OCCUPANCY_EN
        chk("d1_occ", d1_occ, 1);
`endif
        d1_en = 1'b0; d1_iv = 1'b0; d1_in = 2'd0;
        step();
        chk("d1_hold_out", d1_out, 3);
        chk("d1_hold_out_valid", d1_ov, 1);
        d1_en = 1'b1;
        step();
        chk("d1_bubble_out_valid", d1_ov, 0);
        chk("d1_bubble_out", d1_out, 0);
`ifdef DFF_PIPE_OCCUPANCY_EN
        chk("d1_bubble_occ", d1_occ, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
